// File: rtl/spm_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// spm_seq_ctrl_if
//
// Purpose: bundles the two valid/ready channels of the spm sequencer, the
// operand-pair input channel and the product output channel.
//
// Signals:
//   in_valid   operand pair valid              (source -> sequencer)
//   in_ready   sequencer can take a pair       (sequencer -> source)
//   in_x       parallel multiplicand, signed   (source -> sequencer)
//   in_y       serial multiplier, signed       (source -> sequencer)
//   out_valid  product valid                   (sequencer -> consumer)
//   out_ready  consumer accepts the product    (consumer -> sequencer)
//   out_prod   2*WIDTH-bit signed product      (sequencer -> consumer)
//
// Modports:
//   master  operand source / product consumer side
//   slave   sequencer side
// ---------------------------------------------------------------------------
interface spm_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_x;
    logic [WIDTH-1:0]       in_y;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_prod;

    modport master (
        output in_valid,
        output in_x,
        output in_y,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_prod
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  in_y,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_prod
    );
endinterface

// File: rtl/spm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// spm_seq_ctrl
//
// Purpose: sequencer for one serial-parallel multiplier array of WIDTH
// carry-save cells. Accepts a signed operand pair, clears the array, loads
// the parallel operand, streams the serial operand LSB-first with sign
// extension for 2*WIDTH cycles, deserialises the serial product and returns
// the 2*WIDTH-bit signed product.
//
// Parameters:
//   WIDTH  operand width, equal to the spm array size (>= 2)
//   P_LAT  cycles from driving y bit k to product bit k on spm_p (1..3)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      operand / product handshakes (spm_seq_ctrl_if.slave)
//   spm_rst  clear of the array carries and sums
//   spm_x    parallel operand to the array
//   spm_y    serial operand bit to the array
//   spm_p    serial product bit from the array
//   busy     high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module spm_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int P_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    spm_seq_ctrl_if.slave    bus,
    output logic             spm_rst,
    output logic [WIDTH-1:0] spm_x,
    output logic             spm_y,
    input  logic             spm_p,
    output logic             busy
);

    localparam int CNT_W = $clog2(2*WIDTH + P_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(2*WIDTH + P_LAT - 1);
    localparam logic [CNT_W-1:0] SHIFT_START = CNT_W'(P_LAT);
    localparam logic [CNT_W-1:0] SER_END     = CNT_W'(2*WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic signed [WIDTH-1:0]   y_sr;
    logic [2*WIDTH-1:0]        prod;

    assign bus.out_prod = prod;

    // Next-state and control outputs. in_ready depends on state only, so
    // there is no combinational path from out_ready to in_ready.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        spm_rst       = 1'b1;
        spm_y         = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = RUN;
            end
            RUN: begin
                spm_rst = 1'b0;
                // The arithmetic shift register already replicates the sign
                // bit once the operand has been shifted out; stop driving
                // after 2*WIDTH bits so only the latency tail sees zeros.
                if (cnt < SER_END) begin
                    spm_y = y_sr[0];
                end
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state, parallel operand and product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            spm_x <= '0;
            prod  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        spm_x <= bus.in_x;
                    end
                end
                CLEAR: begin
                    cnt <= '0;
                end
                RUN: begin
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // Product bits arrive LSB-first; shifting in at the MSB
                    // leaves bit j at position j after 2*WIDTH shifts.
                    if (cnt >= SHIFT_START) begin
                        prod <= {spm_p, prod[2*WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Serial operand shift register; pure data, loaded on the input handshake.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            y_sr <= $signed(bus.in_y);
        end else if (state == RUN) begin
            y_sr <= y_sr >>> 1;
        end
    end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spm_seq_ctrl
//
// Purpose: directed self-checking bench for spm_seq_ctrl (WIDTH=8, P_LAT=1)
// with an ideal spm array model producing product bit k one cycle after y
// bit k is driven.
// ---------------------------------------------------------------------------
module tb_spm_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int P_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              spm_rst;
    logic [WIDTH-1:0]  spm_x;
    logic              spm_y;
    logic              spm_p = 1'b0;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    spm_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    spm_seq_ctrl #(.WIDTH(WIDTH), .P_LAT(P_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .spm_rst (spm_rst),
        .spm_x   (spm_x),
        .spm_y   (spm_y),
        .spm_p   (spm_p),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Ideal spm array: accumulates x * y_k * 2^k and presents bit k of the
    // running sum one cycle after y bit k was driven.
    logic [15:0] acc = '0;
    int          mk  = 0;

    function automatic logic [15:0] term(input logic y, input logic [7:0] x, input int k);
        logic [15:0] xe;
        xe = {{8{x[7]}}, x};
        if (!y || k >= 16) return 16'h0000;
        return xe << k;
    endfunction

    function automatic logic bit_at(input logic [15:0] v, input int k);
        if (k >= 16) return 1'b0;
        return v[k];
    endfunction

    always @(posedge clk) begin
        if (spm_rst) begin
            acc   <= '0;
            mk    <= 0;
            spm_p <= 1'b0;
        end else begin
            acc   <= acc + term(spm_y, spm_x, mk);
            spm_p <= bit_at(acc + term(spm_y, spm_x, mk), mk);
            mk    <= mk + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid; cyc counts edges since the handshake.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One full transaction with out_ready high; ends in IDLE.
    task automatic run_one(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] exp, output int lat);
        int w;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check(tag, {15'h0, bus.out_valid, bus.out_prod}, {15'h0, 1'b1, exp});
        @(negedge clk);
    endtask

    logic [18:0]        ytr;
    logic [18:0]        rtr;
    logic [7:0]         bx [4];
    logic [7:0]         by [4];
    logic [15:0]        bexp [4];
    int                 hs [4];
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    int                 lat;
    int                 cyc;
    int                 ni;
    int                 no;
    logic               pend;
    logic               seen;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_prod",  bus.out_prod,  0);
        check("rst_spm_rst",   spm_rst,       1);
        check("rst_spm_x",     spm_x,         0);
        check("rst_spm_y",     spm_y,         0);
        check("rst_busy",      busy,          0);
        rst = 1'b0;
        @(negedge clk);

        // Basic product and latency
        run_one("p_3x5", 8'd3, 8'd5, 16'h000F, lat);
        check("lat_3x5",        lat,           18);
        check("busy_after_out", busy,          0);
        check("valid_after_out", bus.out_valid, 0);
        check("ready_after_out", bus.in_ready, 1);

        // Signed extremes
        run_one("p_m1xm1",    8'hFF, 8'hFF, 16'h0001, lat);
        run_one("p_m128sq",   8'h80, 8'h80, 16'h4000, lat);
        run_one("p_127xm128", 8'h7F, 8'h80, 16'hC080, lat);
        run_one("p_0xm77",    8'h00, 8'hB3, 16'h0000, lat);

        // spm_y / spm_rst trace for in_y = 8'h81, x = 2
        bus.in_x      = 8'd2;
        bus.in_y      = 8'h81;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("clear_spm_x", spm_x, 8'd2);
        ytr = '0;
        rtr = '0;
        for (int c = 0; c < 19; c++) begin
            ytr[c] = spm_y;
            rtr[c] = spm_rst;
            if (c < 18) @(negedge clk);
        end
        check("trace_spm_y",   ytr, 19'h1FF02);
        check("trace_spm_rst", rtr, 19'h40001);
        check("p_2xm127", {15'h0, bus.out_valid, bus.out_prod}, {15'h0, 1'b1, 16'hFF02});
        @(negedge clk);

        // Backpressure in DONE
        bus.in_x      = 8'hFB;
        bus.in_y      = 8'h07;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat",  lat,          18);
        check("bp_prod", bus.out_prod, 16'hFFDD);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 8'h55;
            bus.in_y     = 8'h33;
            @(negedge clk);
            check("bp_valid_hold", bus.out_valid, 1);
            check("bp_prod_hold",  bus.out_prod,  16'hFFDD);
            check("bp_in_ready",   bus.in_ready,  0);
            check("bp_spm_x_hold", spm_x,         8'hFB);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_transfer_valid", bus.out_valid, 0);
        check("bp_transfer_ready", bus.in_ready,  1);
        check("bp_transfer_busy",  busy,          0);
        @(negedge clk);

        // Reset in the middle of RUN (k = 6)
        bus.in_x      = 8'd9;
        bus.in_y      = 8'd9;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("mid_run_spm_rst", spm_rst, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_in_ready",  bus.in_ready,  1);
        check("mrst_spm_rst",   spm_rst,       1);
        check("mrst_busy",      busy,          0);
        check("mrst_out_valid", bus.out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("mrst_no_valid", seen, 0);
        run_one("p_2xm3", 8'd2, 8'hFD, 16'hFFFA, lat);

        // Back-to-back random pairs
        for (int i = 0; i < 4; i++) begin
            bx[i]   = 8'($urandom);
            by[i]   = 8'($urandom);
            sx      = $signed(bx[i]);
            sy      = $signed(by[i]);
            bexp[i] = sx * sy;
            hs[i]   = 0;
        end
        cyc  = 0;
        ni   = 0;
        no   = 0;
        pend = 1'b0;
        bus.in_x      = bx[0];
        bus.in_y      = by[0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (no < 4 && cyc < 200) begin
            if (pend) begin
                pend = 1'b0;
                if (ni < 4) begin
                    bus.in_x = bx[ni];
                    bus.in_y = by[ni];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid === 1'b1) begin
                check("b2b_prod", bus.out_prod, bexp[no]);
                no++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1 && ni < 4) begin
                hs[ni] = cyc;
                ni++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("b2b_count", no, 4);
        for (int i = 0; i < 3; i++) begin
            check("b2b_spacing", hs[i+1] - hs[i], 20);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
- Sequencer that drives one serial-parallel multiplier (spm) array of WIDTH carry-save cells (genblk1[i].csa chain).
- Accepts a two's-complement operand pair over a valid/ready handshake, clears the array, and loads the parallel operand.
- Streams the serial operand LSB-first with sign extension, deserialises the serial product, and returns the 2*WIDTH-bit product over a second valid/ready handshake.
- Sits between the operand source and the spm array; it is the only driver of the array's reset, x and y inputs.

Parameters:
- WIDTH, 8: operand width; must match the spm array size (>= 2).
- P_LAT, 1: cycles from driving y bit k to product bit k appearing on spm_p (1..3).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  WIDTH  parallel multiplicand, two's complement.
- in_y  in  WIDTH  serial multiplier, two's complement.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_prod  out  2*WIDTH  signed product in_x*in_y.
- spm_rst  out  1  clear to the spm array carries/sums.
- spm_x  out  WIDTH  parallel operand to the array.
- spm_y  out  1  serial operand bit to the array.
- spm_p  in  1  serial product bit from the array.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge) produces the following state:
  - FSM in IDLE; in_ready=1; out_valid=0; out_prod=0.
  - spm_rst=1; spm_x=0; spm_y=0; busy=0; bit counter=0.
- rst has priority over every other event, including mid-RUN and mid-DONE. A product in flight is discarded and no out_valid is produced for it.
- IDLE:
  - in_ready=1; spm_rst=1; spm_y=0.
  - An in_valid&in_ready edge latches in_x into spm_x and in_y into the shift register, then goes to CLEAR.
- CLEAR (1 cycle):
  - in_ready=0; spm_rst=1; spm_x already holds the new operand.
  - Counter cleared to 0. Next state is RUN.
- RUN (2*WIDTH+P_LAT cycles, counter k = 0..2*WIDTH+P_LAT-1):
  - spm_rst=0.
  - spm_y = in_y[k] for k<WIDTH; in_y[WIDTH-1] (sign extension) for WIDTH<=k<2*WIDTH; 0 after that.
  - For k>=P_LAT, spm_p is shifted into the product register MSB-side; after the final shift, bit j holds product bit j.
  - Leaving RUN on the last count goes to DONE.
  - in_valid is ignored and in_ready=0 throughout.
- DONE:
  - out_valid=1; out_prod stable and held; spm_rst=1; spm_y=0.
  - On out_valid&out_ready, go to IDLE. out_valid drops on the next cycle.
  - No combinational path from out_ready to in_ready: a new operand is accepted at the earliest one cycle after the product handshake.
- Latency from input handshake to out_valid rising: 2*WIDTH+P_LAT+1 cycles (WIDTH=8, P_LAT=1: 18 cycles).
- Arithmetic: result is exact modulo 2^(2*WIDTH), signed. Extreme case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits without overflow.
- Counter width: $clog2(2*WIDTH+P_LAT+1). Counter saturates at the terminal count, never wraps in RUN, and is cleared in CLEAR.
- Simultaneous events:
  - in_valid asserted in DONE is not accepted; in_ready stays 0 until IDLE.
  - out_ready held high permanently gives a back-to-back throughput of one product per 2*WIDTH+P_LAT+3 cycles.
- spm_x is held constant from CLEAR through DONE. It changes only on an accepted input handshake.

Test Plan:
- WIDTH=8, P_LAT=1, ideal spm model: in_x=3, in_y=5 with out_ready=1 -> out_valid rises exactly 18 cycles after the handshake; out_prod=16'h000F; busy low the cycle after the output handshake.
- Signed extremes: (-1)*(-1) -> 16'h0001. (-128)*(-128) -> 16'h4000. 127*(-128) -> 16'hC080. 0*(-77) -> 16'h0000.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_prod stay stable; in_ready=0 and in_valid is ignored; the product transfers on the first out_ready=1 cycle.
- Reset mid-RUN: assert rst at k=6 -> next cycle is IDLE, in_ready=1, spm_rst=1, out_valid never asserts. A following 2*(-3) returns 16'hFFFA.
- spm_y trace for in_y=8'h81 -> 1,0,0,0,0,0,0,1 then 1 (x8), then 0. spm_rst is low only during the 17 RUN cycles.
- Back-to-back: 4 random signed pairs with in_valid and out_ready held high -> each product matches the reference multiplier; handshakes are spaced 20 cycles apart.
